fetch_stage: RTL and testbench

//  IF stage of the 8-bit pipelined CPU; drives the IF/ID pipeline register.
//  - Holds the PC and reads one 16-bit instruction per cycle from a 256-word instruction memory.
//  - Produces pc_f, pcplus1_f, instr_f and is_matrix_mult_f.
//  - Handles hazard-unit stalls, E-stage branch/jump redirects and HALT.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/instr_mem.sv | 27 ++
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes and fetch-state encoding for the 8-bit CPU
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [3:0]         OP_HALT   = 4'hF;
  localparam logic [3:0]         OP_MATMUL = 4'hE;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_t;

  // Top nibble of an instruction word is the opcode
  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - instruction memory: one async read port, one sync write port, no reset
module instr_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic               clk,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata
);

  logic [INSTR_W-1:0] mem [0:DEPTH-1];

  // Program-load write lands at the clock edge, so a same-cycle read still sees the old word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read of the word under the fetch PC
  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, next-PC priority mux, RUN/HALT FSM; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              IMEM_DEPTH = 256,
  parameter logic [PC_W-1:0] RESET_PC   = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallF,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [PC_W-1:0]    pc_f,
  output logic [PC_W-1:0]    pcplus1_f,
  output logic [INSTR_W-1:0] instr_f,
  output logic               is_matrix_mult_f,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_stall_cnt
`endif
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] imem_rdata;
  logic               pc_moves;

  instr_mem #(
    .DEPTH (IMEM_DEPTH)
  ) u_instr_mem (
    .clk   (clk),
    .raddr (pc_f),
    .rdata (imem_rdata),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata)
  );

  assign pcplus1_f = pc_f + 8'd1;

  // While halted the pipeline is fed NOPs so nothing past the HALT word executes
  assign instr_f          = (state == FS_HALT) ? NOP_INSTR : imem_rdata;
  assign is_matrix_mult_f = (opcode_of(instr_f) == OP_MATMUL);
  assign halted           = (state == FS_HALT);

  // PC changes on a redirect, or on a plain advance when neither stalled nor halted
  assign pc_moves = PCSrcE || (!StallF && (state == FS_RUN));

  // PC register and RUN/HALT FSM; a redirect outranks stall and HALT because the halt may be speculative
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f  <= RESET_PC;
      state <= FS_RUN;
    end else if (PCSrcE) begin
      pc_f  <= PCTargetE;
      state <= FS_RUN;
    end else if (StallF) begin
      pc_f  <= pc_f;
    end else if (state == FS_HALT) begin
      pc_f  <= pc_f;
    end else begin
      pc_f <= pcplus1_f;
      if (opcode_of(imem_rdata) == OP_HALT) begin
        state <= FS_HALT;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counts of PC movements and of effective stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= 16'd0;
      perf_stall_cnt <= 16'd0;
    end else begin
      if (pc_moves && (perf_fetch_cnt != 16'hFFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      end
      if (StallF && !PCSrcE && (perf_stall_cnt != 16'hFFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_pc_moves;
  assign unused_pc_moves = pc_moves;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        StallF;
  logic        PCSrcE;
  logic [7:0]  PCTargetE;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic [7:0]  pc_f;
  logic [7:0]  pcplus1_f;
  logic [15:0] instr_f;
  logic        is_matrix_mult_f;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int n_cmp;
  int n_bad;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .StallF           (StallF),
    .PCSrcE           (PCSrcE),
    .PCTargetE        (PCTargetE),
    .imem_we          (imem_we),
    .imem_waddr       (imem_waddr),
    .imem_wdata       (imem_wdata),
    .pc_f             (pc_f),
    .pcplus1_f        (pcplus1_f),
    .instr_f          (instr_f),
    .is_matrix_mult_f (is_matrix_mult_f),
    .halted           (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    tick();
    imem_we    = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    StallF     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = 8'h00;
    imem_we    = 1'b0;
    imem_waddr = 8'h00;
    imem_wdata = 16'h0000;
    #2;

    // Program load under reset: background 10xx, then the directed words
    for (int i = 0; i < 256; i++) begin
      load(8'(i), {8'h10, 8'(i)});
    end
    load(8'h00, 16'h1111);
    load(8'h01, 16'h2222);
    load(8'h02, 16'hE333);
    load(8'h03, 16'h4444);
    load(8'h10, 16'hF000);
    load(8'h11, 16'hE000);
    #1;

    check("rst_pc", 32'(pc_f), 32'h00);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_instr", 32'(instr_f), 32'h1111);
    check("rst_pcplus1", 32'(pcplus1_f), 32'h01);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetch", 32'(perf_fetch_cnt), 32'h0);
    check("rst_perf_stall", 32'(perf_stall_cnt), 32'h0);
`endif

    reset = 1'b0;
    #1;
    check("seq_mm_00", 32'(is_matrix_mult_f), 32'h0);
    tick();
    check("seq_pc_01", 32'(pc_f), 32'h01);
    check("seq_instr_01", 32'(instr_f), 32'h2222);
    check("seq_mm_01", 32'(is_matrix_mult_f), 32'h0);
    tick();
    check("seq_pc_02", 32'(pc_f), 32'h02);
    check("seq_instr_02", 32'(instr_f), 32'hE333);
    check("seq_mm_02", 32'(is_matrix_mult_f), 32'h1);
    tick();
    check("seq_pc_03", 32'(pc_f), 32'h03);
    check("seq_mm_03", 32'(is_matrix_mult_f), 32'h0);
    tick();
    tick();
    check("seq_pc_05", 32'(pc_f), 32'h05);

    // Two-cycle stall at pc 05
    StallF = 1'b1;
    tick();
    check("stall1_pc", 32'(pc_f), 32'h05);
    check("stall1_instr", 32'(instr_f), 32'h1005);
    tick();
    check("stall2_pc", 32'(pc_f), 32'h05);
    check("stall2_instr", 32'(instr_f), 32'h1005);
    StallF = 1'b0;
    tick();
    check("unstall_pc", 32'(pc_f), 32'h06);
    StallF = 1'b1;
    tick();
    StallF = 1'b0;
    tick();
    check("pc_07", 32'(pc_f), 32'h07);
`ifdef FETCH_PERF_CNT_EN
    // 10 edges since reset release: 7 advances, 3 stalls
    check("perf_fetch_10", 32'(perf_fetch_cnt), 32'd7);
    check("perf_stall_10", 32'(perf_stall_cnt), 32'd3);
`endif

    // Redirect beats a same-cycle stall
    PCSrcE    = 1'b1;
    PCTargetE = 8'h40;
    StallF    = 1'b1;
    tick();
    PCSrcE = 1'b0;
    StallF = 1'b0;
    check("redir_pc_40", 32'(pc_f), 32'h40);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_redir", 32'(perf_fetch_cnt), 32'd8);
    check("perf_stall_redir", 32'(perf_stall_cnt), 32'd3);
`endif

    // HALT at 10: word passes once, then NOPs with pc frozen at 11
    PCSrcE    = 1'b1;
    PCTargetE = 8'h10;
    tick();
    PCSrcE = 1'b0;
    check("halt_pc_10", 32'(pc_f), 32'h10);
    check("halt_word", 32'(instr_f), 32'hF000);
    check("halt_pre", 32'(halted), 32'h0);
    tick();
    check("halted_flag", 32'(halted), 32'h1);
    check("halted_nop", 32'(instr_f), 32'h0000);
    check("halted_pc", 32'(pc_f), 32'h11);
    check("halted_mm", 32'(is_matrix_mult_f), 32'h0);
    tick();
    tick();
    check("halted_pc_held", 32'(pc_f), 32'h11);
    check("halted_held", 32'(halted), 32'h1);

    // Speculative halt undone by redirect; then a stalled HALT word waits for release
    PCSrcE    = 1'b1;
    PCTargetE = 8'h10;
    tick();
    PCSrcE = 1'b0;
    StallF = 1'b1;
    check("rehalt_unhalt", 32'(halted), 32'h0);
    tick();
    tick();
    check("stall_halt_pc", 32'(pc_f), 32'h10);
    check("stall_halt_flag", 32'(halted), 32'h0);
    check("stall_halt_instr", 32'(instr_f), 32'hF000);
    StallF = 1'b0;
    tick();
    check("release_halt_flag", 32'(halted), 32'h1);
    check("release_halt_pc", 32'(pc_f), 32'h11);
    PCSrcE    = 1'b1;
    PCTargetE = 8'h20;
    tick();
    PCSrcE = 1'b0;
    check("resume_pc_20", 32'(pc_f), 32'h20);
    check("resume_halted", 32'(halted), 32'h0);
    check("resume_instr", 32'(instr_f), 32'h1020);

    // Same-cycle write to the address being read: old word until the edge
    StallF     = 1'b1;
    imem_we    = 1'b1;
    imem_waddr = 8'h20;
    imem_wdata = 16'hBEEF;
    #1;
    check("wr_old_word", 32'(instr_f), 32'h1020);
    tick();
    imem_we = 1'b0;
    StallF  = 1'b0;
    check("wr_new_word", 32'(instr_f), 32'hBEEF);

    // PC wrap at FF
    PCSrcE    = 1'b1;
    PCTargetE = 8'hFF;
    tick();
    PCSrcE = 1'b0;
    check("wrap_pc_ff", 32'(pc_f), 32'hFF);
    check("wrap_pcplus1", 32'(pcplus1_f), 32'h00);
    check("wrap_instr_ff", 32'(instr_f), 32'h10FF);
    tick();
    check("wrap_pc_00", 32'(pc_f), 32'h00);
    check("wrap_instr_00", 32'(instr_f), 32'h1111);

    // Async reset while stalled at 37
    PCSrcE    = 1'b1;
    PCTargetE = 8'h37;
    tick();
    PCSrcE = 1'b0;
    StallF = 1'b1;
    tick();
    check("pre_rst_pc_37", 32'(pc_f), 32'h37);
    reset = 1'b1;
    #1;
    check("async_rst_pc", 32'(pc_f), 32'h00);
    check("async_rst_halted", 32'(halted), 32'h0);
    PCSrcE    = 1'b1;
    PCTargetE = 8'h55;
    tick();
    check("rst_hold_pc", 32'(pc_f), 32'h00);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetch_clr", 32'(perf_fetch_cnt), 32'h0);
    check("rst_perf_stall_clr", 32'(perf_stall_cnt), 32'h0);
`endif
    PCSrcE = 1'b0;
    StallF = 1'b0;
    reset  = 1'b0;
    tick();
    check("post_rst_pc_01", 32'(pc_f), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
